alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single 32-bit multi-cycle-CPU ALU between two requesters (port 0 = control
//  unit/execute, port 1 = PC/address helper). Round-robin arbitration, operand latching,
//  ALU drive, result capture and a per-requester done pulse. Sits between the requesters
//  and the ALU's A/B/ALU_operation inputs and res/zero outputs.
// PARAMETERS
//  WIDTH   32   operand/result width; must match the ALU
// PORTS
//  clk         in   1      single clock; all state changes on posedge
//  reset       in   1      synchronous, active-high
//  req0        in   1      requester 0 wants an ALU operation
//  op0         in   3      requester 0 ALU_operation code (000 and ... 111 slt)
//  a0, b0      in   WIDTH  requester 0 operands
//  gnt0        out  1      request 0 accepted (1-cycle pulse)
//  done0       out  1      result for requester 0 valid on res/zero (1-cycle pulse)
//  req1,op1,a1,b1,gnt1,done1   same as port 0, for requester 1
//  res         out  WIDTH  captured ALU result; held until next capture
//  zero_out    out  1      captured ALU zero flag; held with res
//  busy        out  1      1 when state != IDLE
//  alu_a       out  WIDTH  to ALU A
//  alu_b       out  WIDTH  to ALU B
//  alu_op      out  3      to ALU ALU_operation
//  alu_res     in   WIDTH  from ALU res
//  alu_zero    in   1      from ALU zero
// BEHAVIOUR
//  Reset (sync): state=IDLE; gnt*, done*, busy = 0; res, alu_a, alu_b = 0; alu_op = 000;
//   zero_out = 0; last_gnt = 1 (requester 0 wins first tie). In-flight op is discarded,
//   no done pulse is issued; reset takes priority over every other event.
//  FSM states: IDLE(00), EXEC(01), DONE(10); 11 is illegal -> IDLE next cycle.
//  Sampling: req0/req1 are sampled only in IDLE and DONE cycles.
//   - neither high: IDLE/DONE -> IDLE.
//   - one high: select it. Both high: select requester != last_gnt.
//   - on select: latch op/a/b of winner into alu_op/alu_a/alu_b, set last_gnt=winner,
//     next state EXEC. gnt<winner> is registered: high for exactly the EXEC cycle.
//  EXEC: ALU driven from latched regs (stable whole cycle); at end of cycle
//   res<=alu_res, zero_out<=alu_zero, next state DONE.
//  DONE: done<winner> high one cycle; res/zero_out valid. Arbitration sampling
//   happens in this same cycle, so back-to-back ops issue every 2 cycles.
//  Latency: req sampled at edge k -> gnt in cycle k+1 -> done/res in cycle k+2.
//  Handshake: requester holds req/op/a/b stable until it sees gnt. Req still high in
//   the cycle after gnt (i.e. the DONE cycle) is a NEW request. Req raised during EXEC
//   is not lost if held; it is sampled in DONE.
//  alu_a/alu_b/alu_op keep the last latched values while idle (no toggling).
//  Only one of gnt0/gnt1 and one of done0/done1 is ever high; gnt and done never
//   high in the same cycle for the same op.
//  Widths: no arithmetic in this block; result/zero passed through unmodified.
// TESTING
//  T1 req0=1,op0=010,a0=5,b0=7 one cycle -> gnt0 next cycle, done0 cycle after, res=12, zero_out=0.
//  T2 req1=1,op1=110,a1=9,b1=9 -> done1 pulse, res=0, zero_out=1; gnt0/done0 stay 0.
//  T3 req0,req1 high together from reset (0:add 1+1, 1:or F0|0F) -> gnt0 first, res=2;
//     then gnt1 in next EXEC, res=0xFF; then with both held, grants alternate 0,1,0.
//  T4 req0 held continuously, op0=111,a0=3,b0=4 -> done0 every 2 cycles, res=1, busy stays 1.
//  T5 reset asserted during EXEC of op0=010,a0=1,b0=2 -> next cycle IDLE, no done0,
//     res=0, alu_op=000, busy=0; following req1 tie-free grant works normally.
//  T6 req1 raised during EXEC of port-0 op and held -> sampled in DONE, gnt1 next cycle.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester handshakes, shared result bus and ALU drive/return signals
// around the ALU share arbiter.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0;
    logic [2:0]       op0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             gnt0;
    logic             done0;

    logic             req1;
    logic [2:0]       op1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt1;
    logic             done1;

    logic [WIDTH-1:0] res;
    logic             zero_out;
    logic             busy;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;

    // arbiter side
    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1, alu_res, alu_zero,
        output gnt0, done0, gnt1, done1, res, zero_out, busy, alu_a, alu_b, alu_op
    );

    // requesters plus ALU side
    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1, alu_res, alu_zero,
        input  gnt0, done0, gnt1, done1, res, zero_out, busy, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one multi-cycle ALU between two requesters: latch the
// winner's operands, drive the ALU for one cycle, capture result, pulse done.
//
// state | meaning
// IDLE  | no op in flight; requests sampled
// EXEC  | ALU driven from latched operands; gnt<winner> high; result captured at end
// DONE  | res/zero_out valid; done<winner> high; requests sampled again
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    alu_share_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             last_gnt;
    logic             sample;
    logic             take;
    logic             winner;
    logic [WIDTH-1:0] a_win;
    logic [WIDTH-1:0] b_win;
    logic [2:0]       op_win;

    // Tie goes to whoever did not win last; a lone request always wins.
    assign sample = (state_q == IDLE) || (state_q == DONE);
    assign take   = sample && (bus.req0 || bus.req1);
    assign winner = (bus.req0 && bus.req1) ? ~last_gnt : bus.req1;
    assign a_win  = winner ? bus.a1  : bus.a0;
    assign b_win  = winner ? bus.b1  : bus.b0;
    assign op_win = winner ? bus.op1 : bus.op0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = take ? EXEC : IDLE;
            EXEC:    state_d = DONE;
            DONE:    state_d = take ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // last_gnt only changes on a new selection, so it still names the owner in EXEC/DONE.
    always_comb begin
        bus.gnt0  = 1'b0;
        bus.gnt1  = 1'b0;
        bus.done0 = 1'b0;
        bus.done1 = 1'b0;
        bus.busy  = (state_q != IDLE);
        if (state_q == EXEC) begin
            bus.gnt0 = ~last_gnt;
            bus.gnt1 = last_gnt;
        end
        if (state_q == DONE) begin
            bus.done0 = ~last_gnt;
            bus.done1 = last_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt     <= 1'b1;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_op   <= 3'b000;
            bus.res      <= '0;
            bus.zero_out <= 1'b0;
        end else begin
            if (take) begin
                last_gnt   <= winner;
                bus.alu_a  <= a_win;
                bus.alu_b  <= b_win;
                bus.alu_op <= op_win;
            end
            if (state_q == EXEC) begin
                bus.res      <= bus.alu_res;
                bus.zero_out <= bus.alu_zero;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic        port;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t sb[$];

    alu_share_arbiter_if #(.WIDTH(32)) bus ();

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.alu_res = '0;
        case (bus.alu_op)
            3'b000: bus.alu_res = bus.alu_a & bus.alu_b;
            3'b001: bus.alu_res = bus.alu_a | bus.alu_b;
            3'b010: bus.alu_res = bus.alu_a + bus.alu_b;
            3'b110: bus.alu_res = bus.alu_a - bus.alu_b;
            3'b111: bus.alu_res = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            default: bus.alu_res = '0;
        endcase
        bus.alu_zero = (bus.alu_res == '0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic port, input logic [31:0] r);
        exp_t e;
        e.port = port;
        e.res  = r;
        e.zero = (r == 32'd0);
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.gnt0 | bus.gnt1) begin
                chk("gnt_excl", {63'd0, bus.gnt0 & bus.gnt1}, 64'd0);
                chk("gnt_done_same", {63'd0, (bus.gnt0 & bus.done0) | (bus.gnt1 & bus.done1)}, 64'd0);
            end
            if (bus.done0 | bus.done1) begin
                chk("done_excl", {63'd0, bus.done0 & bus.done1}, 64'd0);
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", {62'd0, bus.done0, bus.done1}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_port", {63'd0, bus.done1}, {63'd0, e.port});
                    chk("sb_res", {32'd0, bus.res}, {32'd0, e.res});
                    chk("sb_zero", {63'd0, bus.zero_out}, {63'd0, e.zero});
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        bus.req0 = 1'b0; bus.op0 = 3'b000; bus.a0 = '0; bus.b0 = '0;
        bus.req1 = 1'b0; bus.op1 = 3'b000; bus.a1 = '0; bus.b1 = '0;
        cyc(3);
        chk("rst_busy",   {63'd0, bus.busy}, 64'd0);
        chk("rst_res",    {32'd0, bus.res}, 64'd0);
        chk("rst_alu_op", {61'd0, bus.alu_op}, 64'd0);
        chk("rst_gnt",    {62'd0, bus.gnt0, bus.gnt1}, 64'd0);
        chk("rst_done",   {62'd0, bus.done0, bus.done1}, 64'd0);
        reset = 1'b0;
        cyc(1);

        // T1: single add on port 0, latency check
        bus.req0 = 1'b1; bus.op0 = 3'b010; bus.a0 = 32'd5; bus.b0 = 32'd7;
        push(1'b0, 32'd12);
        cyc(1);
        chk("t1_gnt0", {63'd0, bus.gnt0}, 64'd1);
        chk("t1_busy", {63'd0, bus.busy}, 64'd1);
        bus.req0 = 1'b0;
        cyc(1);
        chk("t1_done0", {63'd0, bus.done0}, 64'd1);
        chk("t1_res", {32'd0, bus.res}, 64'd12);
        cyc(1);
        chk("t1_idle", {63'd0, bus.busy}, 64'd0);

        // T2: subtract to zero on port 1
        bus.req1 = 1'b1; bus.op1 = 3'b110; bus.a1 = 32'd9; bus.b1 = 32'd9;
        push(1'b1, 32'd0);
        cyc(1);
        chk("t2_gnt", {62'd0, bus.gnt0, bus.gnt1}, 64'd1);
        bus.req1 = 1'b0;
        cyc(1);
        chk("t2_done", {62'd0, bus.done0, bus.done1}, 64'd1);
        chk("t2_zero", {63'd0, bus.zero_out}, 64'd1);
        cyc(1);

        // T3: tie from reset, then both held alternate 0,1,0
        do_reset();
        bus.req0 = 1'b1; bus.op0 = 3'b010; bus.a0 = 32'd1;    bus.b0 = 32'd1;
        bus.req1 = 1'b1; bus.op1 = 3'b001; bus.a1 = 32'hF0;   bus.b1 = 32'h0F;
        push(1'b0, 32'd2);
        push(1'b1, 32'hFF);
        cyc(1);
        chk("t3_first_gnt0", {63'd0, bus.gnt0}, 64'd1);
        bus.req0 = 1'b0;
        cyc(2);
        chk("t3_then_gnt1", {63'd0, bus.gnt1}, 64'd1);
        bus.req1 = 1'b0;
        cyc(1);
        chk("t3_res_ff", {32'd0, bus.res}, 64'hFF);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        push(1'b0, 32'd2);
        push(1'b1, 32'hFF);
        push(1'b0, 32'd2);
        cyc(1);
        chk("t3_alt0", {62'd0, bus.gnt0, bus.gnt1}, 64'd2);
        cyc(2);
        chk("t3_alt1", {62'd0, bus.gnt0, bus.gnt1}, 64'd1);
        cyc(2);
        chk("t3_alt2", {62'd0, bus.gnt0, bus.gnt1}, 64'd2);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        cyc(2);

        // T4: port 0 held, slt every two cycles
        bus.req0 = 1'b1; bus.op0 = 3'b111; bus.a0 = 32'd3; bus.b0 = 32'd4;
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 32'd1);
            cyc(1);
            chk("t4_gnt0", {63'd0, bus.gnt0}, 64'd1);
            chk("t4_busy_e", {63'd0, bus.busy}, 64'd1);
            if (i == 3) bus.req0 = 1'b0;
            cyc(1);
            chk("t4_done0", {63'd0, bus.done0}, 64'd1);
            chk("t4_busy_d", {63'd0, bus.busy}, 64'd1);
        end
        cyc(1);
        chk("t4_idle", {63'd0, bus.busy}, 64'd0);

        // T5: reset during EXEC discards the op
        bus.req0 = 1'b1; bus.op0 = 3'b010; bus.a0 = 32'd1; bus.b0 = 32'd2;
        cyc(1);
        chk("t5_gnt0", {63'd0, bus.gnt0}, 64'd1);
        bus.req0 = 1'b0;
        reset = 1'b1;
        cyc(1);
        chk("t5_busy", {63'd0, bus.busy}, 64'd0);
        chk("t5_done0", {63'd0, bus.done0}, 64'd0);
        chk("t5_res", {32'd0, bus.res}, 64'd0);
        chk("t5_alu_op", {61'd0, bus.alu_op}, 64'd0);
        reset = 1'b0;
        cyc(1);
        chk("t5_no_done", {62'd0, bus.done0, bus.done1}, 64'd0);
        bus.req1 = 1'b1; bus.op1 = 3'b010; bus.a1 = 32'd20; bus.b1 = 32'd22;
        push(1'b1, 32'd42);
        cyc(1);
        chk("t5_gnt1", {63'd0, bus.gnt1}, 64'd1);
        bus.req1 = 1'b0;
        cyc(2);

        // T6: req1 raised during port-0 EXEC is picked up in DONE
        bus.req0 = 1'b1; bus.op0 = 3'b000; bus.a0 = 32'hFF00; bus.b0 = 32'h0FF0;
        push(1'b0, 32'h0F00);
        cyc(1);
        chk("t6_gnt0", {63'd0, bus.gnt0}, 64'd1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.op1 = 3'b110; bus.a1 = 32'd10; bus.b1 = 32'd3;
        push(1'b1, 32'd7);
        cyc(1);
        chk("t6_no_gnt1_in_done", {63'd0, bus.gnt1}, 64'd0);
        cyc(1);
        chk("t6_gnt1", {63'd0, bus.gnt1}, 64'd1);
        bus.req1 = 1'b0;
        cyc(1);
        chk("t6_alu_op_held", {61'd0, bus.alu_op}, 64'd6);
        cyc(2);
        chk("t6_alu_a_held", {32'd0, bus.alu_a}, 64'd10);

        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end
endmodule
